// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: ID/EX/MEM/WB control registers, load-use stall, branch/jump flush and EX forwarding.
module pipe_ctrl_hazard (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] id_sig,
  input  logic [3:0] id_alu,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_br_taken,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic [9:0] ex_sig,
  output logic [3:0] ex_alu,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [4:0] ex_dst,
  output logic [9:0] mem_sig,
  output logic [4:0] mem_dst,
  output logic       wb_regwrite,
  output logic       wb_memtoreg,
  output logic [4:0] wb_dst,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  logic [4:0] id_dst;
  logic       lu;
  logic       bf;
  always_comb begin
    id_dst = !id_sig[3] ? 5'd0 : id_sig[6] ? 5'd31 : id_sig[7] ? id_rd : id_rt;
    lu = ex_sig[4] && ex_dst != 5'd0 &&
         (ex_dst == id_rs || (ex_dst == id_rt && (id_sig[7] || id_sig[2] || id_sig[1])));
    bf = ex_sig[1] && ex_br_taken;
    pc_stall = !rst && !bf && lu;
    ifid_stall = pc_stall;
    ifid_flush = !rst && (bf || (!lu && id_sig[0]));
    fwd_a = rst ? 2'b00 :
            (mem_sig[3] && mem_dst != 5'd0 && mem_dst == ex_rs) ? 2'b10 :
            (wb_regwrite && wb_dst != 5'd0 && wb_dst == ex_rs) ? 2'b01 : 2'b00;
    fwd_b = rst ? 2'b00 :
            (mem_sig[3] && mem_dst != 5'd0 && mem_dst == ex_rt) ? 2'b10 :
            (wb_regwrite && wb_dst != 5'd0 && wb_dst == ex_rt) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst || bf || lu) begin
      ex_sig <= '0;
      ex_alu <= '0;
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_dst <= '0;
    end else begin
      ex_sig <= id_sig;
      ex_alu <= id_alu;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_dst <= id_dst;
    end
    if (rst) begin
      mem_sig     <= '0;
      mem_dst     <= '0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_dst      <= '0;
    end else begin
      mem_sig     <= ex_sig;
      mem_dst     <= ex_dst;
      wb_regwrite <= mem_sig[3];
      wb_memtoreg <= mem_sig[4];
      wb_dst      <= mem_dst;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// tb_pipe_ctrl_hazard: directed program plus random instruction stream checked against a history-queue model.
module tb_pipe_ctrl_hazard;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] id_sig;
  logic [3:0] id_alu;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_br_taken;
  logic       pc_stall, ifid_stall, ifid_flush;
  logic [9:0] ex_sig, mem_sig;
  logic [3:0] ex_alu;
  logic [4:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic       wb_regwrite, wb_memtoreg;
  logic [1:0] fwd_a, fwd_b;

  pipe_ctrl_hazard dut (
    .clk(clk), .rst(rst), .id_sig(id_sig), .id_alu(id_alu), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_br_taken(ex_br_taken), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .ex_sig(ex_sig), .ex_alu(ex_alu), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .mem_sig(mem_sig), .mem_dst(mem_dst), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] sig;
    logic [3:0] alu;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
  } rec_t;

  rec_t hist[$];
  int   checks = 0;
  int   failures = 0;
  bit   known = 0;
  bit   e_stall, e_flush;
  logic [9:0] ops [0:9];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dst_of(input logic [9:0] s, input logic [4:0] rt, input logic [4:0] rd);
    if (!s[3]) return 5'd0;
    if (s[6]) return 5'd31;
    return s[7] ? rd : rt;
  endfunction

  // newest older writer of src wins: one stage back is MEM, two back is WB
  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    for (int k = 1; k <= 2; k++) begin
      rec_t p = hist[hist.size() - 1 - k];
      if (p.sig[3] && p.dst != 5'd0 && p.dst == src) return k == 1 ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic step(input logic r, input logic [9:0] s, input logic [3:0] a,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic br);
    rec_t ex, mem, wb, nx;
    bit lu_e, bf_e;
    @(negedge clk);
    rst = r; id_sig = s; id_alu = a; id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = br;
    #1;
    ex  = hist[hist.size() - 1];
    mem = hist[hist.size() - 2];
    wb  = hist[hist.size() - 3];
    lu_e = !r && ex.sig[4] && ex.dst != 5'd0 && (ex.dst == rs || ((s[7] || s[2] || s[1]) && ex.dst == rt));
    bf_e = !r && ex.sig[1] && br;
    e_stall = lu_e && !bf_e;
    e_flush = bf_e || (!r && !lu_e && s[0]);
    if (known) begin
      check("pc_stall", pc_stall, e_stall);
      check("ifid_stall", ifid_stall, e_stall);
      check("ifid_flush", ifid_flush, e_flush);
      check("ex_sig", ex_sig, ex.sig);
      check("ex_alu", ex_alu, ex.alu);
      check("ex_rs", ex_rs, ex.rs);
      check("ex_rt", ex_rt, ex.rt);
      check("ex_dst", ex_dst, ex.dst);
      check("mem_sig", mem_sig, mem.sig);
      check("mem_dst", mem_dst, mem.dst);
      check("wb_regwrite", wb_regwrite, wb.sig[3]);
      check("wb_memtoreg", wb_memtoreg, wb.sig[4]);
      check("wb_dst", wb_dst, wb.dst);
      check("fwd_a", fwd_a, r ? 2'b00 : fwd_of(ex.rs));
      check("fwd_b", fwd_b, r ? 2'b00 : fwd_of(ex.rt));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) hist.push_back('0);
      known = 1;
    end else begin
      nx = (bf_e || lu_e) ? rec_t'(0) : rec_t'{sig: s, alu: a, rs: rs, rt: rt, dst: dst_of(s, rt, rd)};
      hist.push_back(nx);
    end
    while (hist.size() > 3) void'(hist.pop_front());
  endtask

  // emulates IF/ID: held while stalled, replaced by a NOP after a flush
  task automatic issue(input logic r, input logic [9:0] s, input logic [3:0] a,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic br);
    int n = 0;
    do begin
      step(r, s, a, rs, rt, rd, br);
      n++;
    end while (e_stall && n < 4);
    if (e_stall) check("stall_bound", 32'(n), 32'd1);
    if (e_flush) step(1'b0, 10'h000, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  function automatic logic [4:0] rreg();
    int k = $urandom_range(5);
    return k == 5 ? 5'd31 : k == 4 ? 5'd8 : 5'(k);
  endfunction

  initial begin
    ops[0] = 10'h088; ops[1] = 10'h038; ops[2] = 10'h024; ops[3] = 10'h002; ops[4] = 10'h202;
    ops[5] = 10'h028; ops[6] = 10'h001; ops[7] = 10'h049; ops[8] = 10'h000; ops[9] = 10'h128;
    for (int i = 0; i < 3; i++) hist.push_back('0);
    rst = 1'b1; id_sig = '0; id_alu = '0; id_rs = '0; id_rt = '0; id_rd = '0; ex_br_taken = 1'b0;
    step(1'b1, 10'h088, 4'h2, 5'd1, 5'd2, 5'd3, 1'b0);
    step(1'b1, 10'h088, 4'h2, 5'd1, 5'd2, 5'd3, 1'b0);
    issue(1'b0, 10'h088, 4'h2, 5'd1, 5'd2, 5'd3, 1'b0);
    issue(1'b0, 10'h038, 4'h2, 5'd1, 5'd8, 5'd0, 1'b0);
    issue(1'b0, 10'h088, 4'h2, 5'd8, 5'd2, 5'd9, 1'b0);
    issue(1'b0, 10'h028, 4'h2, 5'd0, 5'd5, 5'd0, 1'b0);
    issue(1'b0, 10'h028, 4'h2, 5'd0, 5'd5, 5'd0, 1'b0);
    issue(1'b0, 10'h088, 4'h2, 5'd5, 5'd5, 5'd6, 1'b0);
    issue(1'b0, 10'h028, 4'h2, 5'd0, 5'd5, 5'd0, 1'b0);
    issue(1'b0, 10'h028, 4'h2, 5'd0, 5'd5, 5'd0, 1'b0);
    issue(1'b0, 10'h000, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    issue(1'b0, 10'h088, 4'h2, 5'd5, 5'd5, 5'd6, 1'b0);
    issue(1'b0, 10'h028, 4'h2, 5'd0, 5'd0, 5'd0, 1'b0);
    issue(1'b0, 10'h088, 4'h2, 5'd0, 5'd0, 5'd7, 1'b0);
    issue(1'b0, 10'h038, 4'h2, 5'd1, 5'd8, 5'd0, 1'b0);
    issue(1'b0, 10'h002, 4'h6, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(1'b0, 10'h088, 4'h2, 5'd8, 5'd2, 5'd9, 1'b1);
    issue(1'b0, 10'h049, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) issue(1'b0, 10'h000, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 500; i++)
      issue($urandom_range(39) == 0, ops[$urandom_range(9)], 4'($urandom_range(15)),
            rreg(), rreg(), rreg(), 1'($urandom_range(1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
